// File: rtl/cash_vault_arbiter.sv
// rtl/cash_vault_arbiter.sv - four-terminal round-robin cash withdrawal arbiter with vault and daily-limit checks
// Optional audit counters enabled by defining CASH_VAULT_AUDIT_EN.
module cash_vault_arbiter #(
    parameter logic [19:0] VAULT_INIT  = 20'd500000,
    parameter logic [15:0] DAILY_LIMIT = 16'd15000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] req_amt,
    input  logic        refill,
    input  logic [19:0] refill_amt,
    input  logic        day_clr,
    output logic [3:0]  gnt,
    output logic        approve,
    output logic [1:0]  deny_code,
    output logic [19:0] vault_bal,
    output logic        busy,
    output logic [15:0] txn_cnt,
    output logic [15:0] deny_cnt
);

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t      state;
    logic [1:0]  last_w;
    logic [1:0]  win;
    logic [15:0] amt;
    logic [15:0] day_total [4];

    logic [1:0]  pick;
    logic        found;
    logic [16:0] day_sum;
    logic [1:0]  code;
    logic        ok;
    logic [20:0] bal_next;
    logic [19:0] bal_sat;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        pick  = last_w;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[2'(last_w + 2'(k))]) begin
                pick  = 2'(last_w + 2'(k));
                found = 1'b1;
            end
        end
    end

    always_comb begin
        day_sum = {1'b0, day_total[win]} + {1'b0, amt};
        if (amt == 16'd0)
            code = 2'b01;
        else if (day_sum > {1'b0, DAILY_LIMIT})
            code = 2'b10;
        else if ({4'b0, amt} > vault_bal)
            code = 2'b11;
        else
            code = 2'b00;
        ok = (code == 2'b00);
    end

    // Decision uses the pre-refill balance; debit never exceeds the balance so only the top saturates.
    always_comb begin
        bal_next = {1'b0, vault_bal}
                 - ((state == CHECK && ok) ? {5'b0, amt} : 21'd0)
                 + (refill ? {1'b0, refill_amt} : 21'd0);
        bal_sat  = bal_next[20] ? 20'hFFFFF : bal_next[19:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_w    <= 2'd3;
            win       <= 2'd0;
            amt       <= 16'd0;
            vault_bal <= VAULT_INIT;
            gnt       <= 4'b0;
            approve   <= 1'b0;
            deny_code <= 2'b00;
            busy      <= 1'b0;
            for (int i = 0; i < 4; i++) day_total[i] <= 16'd0;
        end else begin
            vault_bal <= bal_sat;
            case (state)
                IDLE: begin
                    if (found) begin
                        win    <= pick;
                        last_w <= pick;
                        amt    <= req_amt[{pick, 4'b0000} +: 16];
                        state  <= CHECK;
                        busy   <= 1'b1;
                    end
                end
                CHECK: begin
                    gnt       <= 4'b0001 << win;
                    approve   <= ok;
                    deny_code <= code;
                    state     <= RESP;
                    if (ok) day_total[win] <= day_sum[15:0];
                end
                default: begin
                    gnt       <= 4'b0;
                    approve   <= 1'b0;
                    deny_code <= 2'b00;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
            // Clear overrides any same-edge accumulation.
            if (day_clr)
                for (int i = 0; i < 4; i++) day_total[i] <= 16'd0;
        end
    end

`ifdef CASH_VAULT_AUDIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt  <= 16'd0;
            deny_cnt <= 16'd0;
        end else if (state == CHECK) begin
            if (ok && txn_cnt != 16'hFFFF)
                txn_cnt <= txn_cnt + 16'd1;
            if (!ok && deny_cnt != 16'hFFFF)
                deny_cnt <= deny_cnt + 16'd1;
        end
    end
`else
    assign txn_cnt  = 16'd0;
    assign deny_cnt = 16'd0;
`endif

endmodule
